// File: rtl/stream_arbiter_pkg.sv
// Shared types and helpers for the QoS stream arbiter: arbiter state encoding
// and the width of an internal stream index.
package stream_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // An index always needs at least one bit, even for a two-stream arbiter.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qos_rr_select.sv
// Combinational max-QoS finder. Candidates are scanned starting at rr_ptr_i with
// wrap-around, so the first of several equal-QoS candidates in that order wins.
module qos_rr_select
  import stream_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int QW = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [QW-1:0] qos_i [N],
  input  logic [IW-1:0] rr_ptr_i,
  output logic [IW-1:0] win_o,
  output logic          any_valid_o
);

  logic [QW-1:0] best_qos;
  int            idx;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    best_qos    = '0;
    idx         = 0;
    win_o       = '0;
    any_valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= N) idx -= N;
      // Strict '>' keeps the earliest candidate in scan order on a tie.
      if (valid_i[idx] && (!any_valid_o || qos_i[idx] > best_qos)) begin
        any_valid_o = 1'b1;
        best_qos    = qos_i[idx];
        win_o       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// N-to-1 valid/ready stream arbiter with packet locking and QoS priority.
// Define STREAM_ARB_RR_TIE_EN for round-robin tie-break; otherwise lowest index wins ties.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int STREAM_COUNT = 2,
  parameter int T_QOS__WIDTH = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_ID___WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i  [STREAM_COUNT],
  input  logic [T_QOS__WIDTH-1:0] s_qos_i   [STREAM_COUNT],
  input  logic [STREAM_COUNT-1:0] s_last_i,
  input  logic [STREAM_COUNT-1:0] s_valid_i,
  output logic [STREAM_COUNT-1:0] s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  input  logic                    m_ready_i
);

  localparam int SEL_W = id_width(STREAM_COUNT);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] lock_id_q, lock_id_d;
  logic [SEL_W-1:0] sel, win, rr_ptr;
  logic             any_valid, active, xfer;

`ifdef STREAM_ARB_RR_TIE_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  qos_rr_select #(
    .N  (STREAM_COUNT),
    .QW (T_QOS__WIDTH),
    .IW (SEL_W)
  ) u_select (
    .valid_i     (s_valid_i),
    .qos_i       (s_qos_i),
    .rr_ptr_i    (rr_ptr),
    .win_o       (win),
    .any_valid_o (any_valid)
  );

  // A locked stream stays selected even when it drops valid mid-packet.
  always_comb begin
    sel    = '0;
    active = 1'b0;
    if (state_q == BUSY) begin
      sel    = lock_id_q;
      active = 1'b1;
    end else if (any_valid) begin
      sel    = win;
      active = 1'b1;
    end
  end

  // rst_n is active-high here: outputs are forced to zero while it is 1.
  always_comb begin
    m_data_o  = '0;
    m_qos_o   = '0;
    m_last_o  = 1'b0;
    m_valid_o = 1'b0;
    m_id_o    = '0;
    s_ready_o = '0;
    if (active && !rst_n) begin
      m_data_o       = s_data_i[sel];
      m_qos_o        = s_qos_i[sel];
      m_last_o       = s_last_i[sel];
      m_valid_o      = s_valid_i[sel];
      m_id_o         = T_ID___WIDTH'(sel);
      s_ready_o[sel] = m_ready_i;
    end
  end

  assign xfer = m_valid_o & m_ready_i;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      if (m_last_o) begin
        state_d = IDLE;
      end else begin
        state_d   = BUSY;
        lock_id_d = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all update together.
    if (rst_n) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

`ifdef STREAM_ARB_RR_TIE_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && m_last_o)
      rr_ptr_d = (sel == SEL_W'(STREAM_COUNT - 1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed, table-driven bench for stream_arbiter (two streams, default widths).
module tb_stream_arbiter;

`ifdef STREAM_ARB_RR_TIE_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data [2];
  logic [3:0] s_qos  [2];
  logic [1:0] s_last;
  logic [1:0] s_valid;
  logic [1:0] s_ready;
  logic [7:0] m_data;
  logic [3:0] m_qos;
  logic       m_last;
  logic       m_valid;
  logic [0:0] m_id;
  logic       m_ready;

  int checks = 0;
  int errors = 0;

  stream_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_qos_i   (s_qos),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_qos_o   (m_qos),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_id_o    (m_id),
    .m_ready_i (m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] valid;
    logic [3:0] q0, q1;
    logic [7:0] d0, d1;
    logic [1:0] last;
    logic       rdy;
    logic       e_valid;
    logic       e_id;
    logic [7:0] e_data;
    logic [3:0] e_qos;
    logic       e_last;
    logic [1:0] e_ready;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [1:0] valid,
                              input logic [3:0] q0, input logic [3:0] q1,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] last, input logic rdy,
                              input logic e_valid, input logic e_id,
                              input logic [7:0] e_data, input logic [3:0] e_qos,
                              input logic e_last, input logic [1:0] e_ready);
    vec_t v;
    v.name = name; v.valid = valid; v.q0 = q0; v.q1 = q1; v.d0 = d0; v.d1 = d1;
    v.last = last; v.rdy = rdy; v.e_valid = e_valid; v.e_id = e_id;
    v.e_data = e_data; v.e_qos = e_qos; v.e_last = e_last; v.e_ready = e_ready;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    s_valid   = v.valid;
    s_qos[0]  = v.q0;
    s_qos[1]  = v.q1;
    s_data[0] = v.d0;
    s_data[1] = v.d1;
    s_last    = v.last;
    m_ready   = v.rdy;
  endtask

  task automatic check_outs(input vec_t v);
    check({v.name, ".m_valid"}, 32'(m_valid), 32'(v.e_valid));
    check({v.name, ".m_id"},    32'(m_id),    32'(v.e_id));
    check({v.name, ".m_data"},  32'(m_data),  32'(v.e_data));
    check({v.name, ".m_qos"},   32'(m_qos),   32'(v.e_qos));
    check({v.name, ".m_last"},  32'(m_last),  32'(v.e_last));
    check({v.name, ".s_ready"}, 32'(s_ready), 32'(v.e_ready));
  endtask

  // Drive at the falling edge, sample 1 ns later, commit at the next rising edge.
  task automatic cyc(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check_outs(v);
  endtask

  vec_t tbl [9];
  vec_t v;

  initial begin
    // Stream 0 (higher QoS) sends AA,BB then stream 1 sends CC,DD; then idle, then
    // a higher-QoS stream 1 beat, a stalled stream 0 beat and a stream 1 beat.
    tbl[0] = mk("prio_aa",  2'b11, 4'h3, 4'h2, 8'hAA, 8'hCC, 2'b00, 1'b1, 1'b1, 1'b0, 8'hAA, 4'h3, 1'b0, 2'b01);
    tbl[1] = mk("prio_bb",  2'b11, 4'h3, 4'h2, 8'hBB, 8'hCC, 2'b01, 1'b1, 1'b1, 1'b0, 8'hBB, 4'h3, 1'b1, 2'b01);
    tbl[2] = mk("prio_cc",  2'b10, 4'h3, 4'h2, 8'hBB, 8'hCC, 2'b00, 1'b1, 1'b1, 1'b1, 8'hCC, 4'h2, 1'b0, 2'b10);
    tbl[3] = mk("prio_dd",  2'b10, 4'h3, 4'h2, 8'hBB, 8'hDD, 2'b10, 1'b1, 1'b1, 1'b1, 8'hDD, 4'h2, 1'b1, 2'b10);
    tbl[4] = mk("idle",     2'b00, 4'h3, 4'h2, 8'hBB, 8'hDD, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'b00);
    tbl[5] = mk("hiq1",     2'b11, 4'h1, 4'h5, 8'h11, 8'h22, 2'b11, 1'b1, 1'b1, 1'b1, 8'h22, 4'h5, 1'b1, 2'b10);
    tbl[6] = mk("stall0",   2'b01, 4'h0, 4'h5, 8'h33, 8'h22, 2'b01, 1'b0, 1'b1, 1'b0, 8'h33, 4'h0, 1'b1, 2'b00);
    tbl[7] = mk("go0",      2'b01, 4'h0, 4'h5, 8'h33, 8'h22, 2'b01, 1'b1, 1'b1, 1'b0, 8'h33, 4'h0, 1'b1, 2'b01);
    tbl[8] = mk("single1",  2'b10, 4'h0, 4'h0, 8'h33, 8'h44, 2'b10, 1'b1, 1'b1, 1'b1, 8'h44, 4'h0, 1'b1, 2'b10);

    // Outputs must be zero while in reset even with requests present.
    rst_n = 1'b1;
    drive(mk("rst", 2'b11, 4'h3, 4'h1, 8'h5A, 8'hA5, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'b00));
    #2;
    check_outs(mk("reset", 2'b11, 4'h3, 4'h1, 8'h5A, 8'hA5, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'b00));
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 2'b00;

    for (int i = 0; i < 9; i++) cyc(tbl[i]);

    // Lock: stream 0 keeps the output through a valid gap and a QoS rise on stream 1.
    cyc(mk("lock_b0",   2'b01, 4'h1, 4'h0, 8'h10, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 8'h10, 4'h1, 1'b0, 2'b01));
    cyc(mk("lock_gap",  2'b10, 4'h1, 4'hF, 8'h10, 8'h99, 2'b10, 1'b1, 1'b0, 1'b0, 8'h10, 4'h1, 1'b0, 2'b01));
    cyc(mk("lock_b1",   2'b11, 4'h7, 4'hF, 8'h11, 8'h99, 2'b10, 1'b1, 1'b1, 1'b0, 8'h11, 4'h7, 1'b0, 2'b01));
    cyc(mk("lock_end",  2'b11, 4'h1, 4'hF, 8'h12, 8'h99, 2'b11, 1'b1, 1'b1, 1'b0, 8'h12, 4'h1, 1'b1, 2'b01));
    cyc(mk("lock_next", 2'b10, 4'h1, 4'hF, 8'h12, 8'h99, 2'b10, 1'b1, 1'b1, 1'b1, 8'h99, 4'hF, 1'b1, 2'b10));

    // Backpressure mid-packet on stream 1 while a higher-QoS stream 0 waits.
    cyc(mk("bp_start",  2'b10, 4'h0, 4'h4, 8'h00, 8'h50, 2'b00, 1'b1, 1'b1, 1'b1, 8'h50, 4'h4, 1'b0, 2'b10));
    for (int i = 0; i < 3; i++)
      cyc(mk("bp_stall", 2'b11, 4'hF, 4'h4, 8'hEE, 8'h51, 2'b00, 1'b0, 1'b1, 1'b1, 8'h51, 4'h4, 1'b0, 2'b00));
    cyc(mk("bp_resume", 2'b11, 4'hF, 4'h4, 8'hEE, 8'h51, 2'b00, 1'b1, 1'b1, 1'b1, 8'h51, 4'h4, 1'b0, 2'b10));
    cyc(mk("bp_last",   2'b11, 4'hF, 4'h4, 8'hEE, 8'h52, 2'b10, 1'b1, 1'b1, 1'b1, 8'h52, 4'h4, 1'b1, 2'b10));
    cyc(mk("bp_idle",   2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'b00));

    // Equal-QoS single-beat packets: alternating with round-robin, else always 0.
    for (int i = 0; i < 4; i++) begin
      logic       id;
      logic [7:0] d0, d1;
      id = RR_EN ? i[0] : 1'b0;
      d0 = 8'hA0 + 8'(i);
      d1 = 8'hB0 + 8'(i);
      cyc(mk("tie", 2'b11, 4'h2, 4'h2, d0, d1, 2'b11, 1'b1, 1'b1, id,
             id ? d1 : d0, 4'h2, 1'b1, id ? 2'b10 : 2'b01));
    end

    // Reset mid-packet while stream 1 is locked, then equal QoS goes to stream 0.
    cyc(mk("rs_pre0",   2'b01, 4'h2, 4'h2, 8'h60, 8'h00, 2'b01, 1'b1, 1'b1, 1'b0, 8'h60, 4'h2, 1'b1, 2'b01));
    cyc(mk("rs_pre1",   2'b10, 4'h2, 4'h2, 8'h60, 8'h77, 2'b00, 1'b1, 1'b1, 1'b1, 8'h77, 4'h2, 1'b0, 2'b10));
    v = mk("rs_locked", 2'b11, 4'h2, 4'h2, 8'h55, 8'h78, 2'b00, 1'b1, 1'b1, 1'b1, 8'h78, 4'h2, 1'b0, 2'b10);
    cyc(v);
    #1;
    rst_n = 1'b1;
    #1;
    check_outs(mk("rs_async", 2'b11, 4'h2, 4'h2, 8'h55, 8'h78, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'b00));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outs(mk("rs_after", 2'b11, 4'h2, 4'h2, 8'h55, 8'h78, 2'b00, 1'b1, 1'b1, 1'b0, 8'h55, 4'h2, 1'b0, 2'b01));
    cyc(mk("rs_end",    2'b11, 4'h2, 4'h2, 8'h56, 8'h78, 2'b01, 1'b1, 1'b1, 1'b0, 8'h56, 4'h2, 1'b1, 2'b01));
    cyc(mk("end_idle",  2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- N-input to 1-output valid/ready stream multiplexer with packet-granular, QoS-priority arbitration.
- Sits in front of a shared downstream sink. Each input carries data, QoS, last and valid; the output adds the index of the winning stream.
- Once a packet is granted, its stream keeps the output until its last beat is accepted.

Parameters:
- STREAM_COUNT, 2, number of input streams (>=2).
- T_QOS__WIDTH, 4, QoS field width; larger value = higher priority.
- T_DATA_WIDTH, 8, data beat width.
- T_ID___WIDTH, 1, output stream-index width; must be >= clog2(STREAM_COUNT).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-HIGH reset (1 = reset, despite the name).
- s_data_i  in  [T_DATA_WIDTH-1:0] x STREAM_COUNT (unpacked array)  input data.
- s_qos_i  in  [T_QOS__WIDTH-1:0] x STREAM_COUNT (unpacked array)  input QoS, sampled at packet start.
- s_last_i  in  STREAM_COUNT  per-stream last-beat flag.
- s_valid_i  in  STREAM_COUNT  per-stream valid.
- s_ready_o  out  STREAM_COUNT  per-stream ready.
- m_data_o  out  T_DATA_WIDTH  selected data.
- m_qos_o  out  T_QOS__WIDTH  selected stream's QoS.
- m_last_o  out  1  selected last.
- m_valid_o  out  1  output valid.
- m_id_o  out  T_ID___WIDTH  index of selected stream.
- m_ready_i  in  1  downstream ready.

Behaviour:
- State: IDLE (no packet locked) and BUSY (locked stream index `lock_id`). Also a round-robin pointer `rr_ptr`.
- Reset (async, rst_n=1): state=IDLE, lock_id=0, rr_ptr=0. While in reset, all outputs are 0, including s_ready_o and m_valid_o.
- Arbitration in IDLE (combinational, zero latency):
  - Candidates are the streams with s_valid_i=1.
  - Winner is the candidate with the highest s_qos_i.
  - Ties are broken round-robin: the first tied candidate at or after rr_ptr, in increasing index order with wrap-around.
- Arbitration in BUSY: the selected stream is lock_id regardless of the QoS or valid of other streams.
- Datapath (combinational from the selected stream sel):
  - m_data_o, m_qos_o, m_last_o = stream sel's fields.
  - m_valid_o = s_valid_i[sel].
  - m_id_o = sel.
- Outputs when IDLE with no candidate: m_valid_o=0, and m_data_o, m_qos_o, m_last_o, m_id_o = 0.
- Ready: s_ready_o[sel] = m_ready_i; all other bits are 0. A stream is never granted ready without being selected.
- Transfer means m_valid_o & m_ready_i.
- Transitions:
  - IDLE, transfer with last=0 → BUSY, lock_id=sel.
  - IDLE, transfer with last=1 (single-beat packet) → stays IDLE.
  - BUSY, transfer with last=1 → IDLE.
  - Every last-beat transfer sets rr_ptr = (sel+1) mod STREAM_COUNT.
- Stalls: m_ready_i=0 holds the state; output fields follow the selected input, whose data must be held by the source per protocol.
- In BUSY, if the locked stream drops valid: m_valid_o=0 and the lock is held (no re-arbitration mid-packet).
- QoS changes mid-packet have no effect on the grant; m_qos_o still mirrors the current s_qos_i[sel].
- Reset asserted mid-packet: the lock is abandoned and arbitration restarts in IDLE after deassertion.

Optional Feature:
- STREAM_ARB_RR_TIE_EN
  - Defined: ties broken round-robin via rr_ptr, as specified above.
  - Undefined: rr_ptr is removed and ties go to the lowest index (fixed priority); all other behaviour is unchanged.

Decomposition:
- Package stream_arbiter_pkg holds the arbiter state enum (IDLE, BUSY) and a clog2-based id-width helper function.
- One natural sub-module: qos_rr_select, a combinational max-QoS finder with rotating tie-break. Inputs: valid vector, QoS array, rr_ptr. Outputs: winner index, any_valid.

Test Plan:
- Priority: both streams valid, qos0=3 data AA then BB (last), qos1=2 data CC, m_ready_i=1 → m_id_o=0 and data AA, BB with m_last_o on BB, s_ready_o=01; next cycle m_id_o=1, data CC then DD (last), s_ready_o=10; then m_valid_o=0.
- Lock: stream 0 packet in progress (qos 1); stream 1 raises qos F mid-packet → stream 0 keeps the output until its last beat, then stream 1 is selected.
- Backpressure: m_ready_i=0 for 3 cycles mid-packet → state and selection unchanged, s_ready_o=0, no beat lost.
- Tie with STREAM_ARB_RR_TIE_EN defined: both streams qos 2, single-beat packets → grants alternate 0,1,0,1. Without the macro → always 0 while stream 0 is valid.
- Reset: assert rst_n=1 mid-packet → all outputs 0 immediately (async); after release, equal-QoS requests are granted to stream 0.
- Idle: no valid inputs → m_valid_o=0, m_data_o=0, m_id_o=0, s_ready_o=0.
